// File: rtl/hamming74_pkg.sv
// Shared definitions for the Hamming(7,4) serial link: FSM states,
// codeword bit positions and io_out bit indices.
package hamming74_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  // Codeword vector bit n-1 holds c_n, so c1 is bit 0 and arrives first.
  localparam int unsigned POS_P1 = 0;
  localparam int unsigned POS_P2 = 1;
  localparam int unsigned POS_D0 = 2;
  localparam int unsigned POS_P4 = 3;
  localparam int unsigned POS_D1 = 4;
  localparam int unsigned POS_D2 = 5;
  localparam int unsigned POS_D3 = 6;

  localparam int unsigned O_DATA_LSB = 0;
  localparam int unsigned O_VALID    = 4;
  localparam int unsigned O_CORR     = 5;
  localparam int unsigned O_FERR     = 6;
  localparam int unsigned O_BUSY     = 7;

endpackage

// File: rtl/hamming74_decode.sv
// Combinational Hamming(7,4) single-error corrector: syndrome, corrected
// codeword and extracted data nibble.
module hamming74_decode
  import hamming74_pkg::*;
(
  input  logic [6:0] i_code,
  output logic [3:0] o_data,
  output logic [2:0] o_syn,
  output logic       o_corrected
);

  logic [6:0] w_fix;

  assign o_syn[0] = i_code[POS_P1] ^ i_code[POS_D0] ^ i_code[POS_D1] ^ i_code[POS_D3];
  assign o_syn[1] = i_code[POS_P2] ^ i_code[POS_D0] ^ i_code[POS_D2] ^ i_code[POS_D3];
  assign o_syn[2] = i_code[POS_P4] ^ i_code[POS_D1] ^ i_code[POS_D2] ^ i_code[POS_D3];

  // The syndrome names the 1-based position of the flipped bit.
  always_comb begin
    w_fix = i_code;
    if (o_syn != 3'd0) w_fix[o_syn - 3'd1] = ~i_code[o_syn - 3'd1];
  end

  assign o_data      = {w_fix[POS_D3], w_fix[POS_D2], w_fix[POS_D1], w_fix[POS_D0]};
  assign o_corrected = (o_syn != 3'd0);

endmodule

// File: rtl/hamming74_serial_rx.sv
// Oversampling serial receiver for Hamming(7,4) frames on the TinyTapeout
// pin interface: sync, framing FSM, shift register and registered outputs.
module hamming74_serial_rx
  import hamming74_pkg::*;
#(
  parameter int CLKS_PER_BIT = 2
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  logic          w_clk, w_rst_n, w_rxd;
  logic          r_sync1, r_sync2;
  state_e        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_idx, w_idx_nxt;
  logic [6:0]    r_code;
  logic [3:0]    r_data;
  logic          r_valid, r_corr, r_ferr;
  logic          w_shift, w_confirm, w_stop_ok, w_stop_bad;
  logic [3:0]    w_data;
  logic [2:0]    w_syn;
  logic          w_corr;
  logic          w_unused;

  assign w_clk    = io_in[0];
  assign w_rst_n  = io_in[1];
  assign w_rxd    = io_in[2];
  assign w_unused = &{1'b0, io_in[7:3], w_syn};

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= w_rxd;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_idx_nxt   = r_idx;
    w_shift     = 1'b0;
    w_confirm   = 1'b0;
    w_stop_ok   = 1'b0;
    w_stop_bad  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (!r_sync2) w_state_nxt = ST_START;
      end
      ST_START: begin
        if (r_cnt == CW'(HALF - 1)) begin
          w_cnt_nxt = '0;
          if (r_sync2) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_confirm   = 1'b1;
            w_idx_nxt   = '0;
            w_state_nxt = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (r_cnt == CW'(CLKS_PER_BIT - 1)) begin
          w_cnt_nxt = '0;
          w_shift   = 1'b1;
          if (r_idx == 3'd6) w_state_nxt = ST_STOP;
          else               w_idx_nxt   = r_idx + 3'd1;
        end
      end
      ST_STOP: begin
        if (r_cnt == CW'(CLKS_PER_BIT - 1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
          w_stop_ok   = r_sync2;
          w_stop_bad  = ~r_sync2;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) r_code <= '0;
    else if (w_shift) r_code[r_idx] <= r_sync2;
  end

  hamming74_decode u_dec (
    .i_code      (r_code),
    .o_data      (w_data),
    .o_syn       (w_syn),
    .o_corrected (w_corr)
  );

  // A bad stop bit keeps the last good data and corrected flag visible.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_corr  <= 1'b0;
      r_ferr  <= 1'b0;
    end else if (w_confirm) begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else if (w_stop_ok) begin
      r_data  <= w_data;
      r_valid <= 1'b1;
      r_corr  <= w_corr;
    end else if (w_stop_bad) begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b1;
    end
  end

  assign io_out[O_DATA_LSB +: 4] = r_data;
  assign io_out[O_VALID]         = r_valid;
  assign io_out[O_CORR]          = r_corr;
  assign io_out[O_FERR]          = r_ferr;
  assign io_out[O_BUSY]          = (r_state != ST_IDLE);

endmodule

// File: tb/tb_hamming74_serial_rx.sv
// Scoreboard bench for hamming74_serial_rx: frames are encoded here, the
// expected outputs queued at drive time and popped when each frame completes.
module tb_hamming74_serial_rx;
  localparam int CPB = 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd   = 1'b1;
  logic [7:0] io_in;
  logic [7:0] io_out;

  assign io_in = {5'b0, rxd, rst_n, clk};

  hamming74_serial_rx #(.CLKS_PER_BIT(CPB)) u_dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] dat;
    logic       vld;
    logic       cor;
    logic       fer;
  } exp_t;

  exp_t sb[$];
  exp_t m = '0;
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic logic [6:0] encode(input logic [3:0] d);
    logic p1, p2, p4;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p4 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p4, d[0], p2, p1};
  endfunction

  function automatic logic [6:0] exp_vec(input exp_t e);
    return {e.fer, e.cor, e.vld, e.dat};
  endfunction

  // Bits change 1 ns after a rising edge; align=0 continues straight on
  // from the previous frame's stop bit.
  task automatic drive_frame(input logic [6:0] code, input logic stop, input bit align);
    if (align) begin @(posedge clk); #1; end
    rxd = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) begin
      rxd = code[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rxd = stop;
    repeat (CPB) @(posedge clk);
    #1;
    rxd = 1'b1;
  endtask

  task automatic send(input logic [3:0] d, input int flip, input logic stop, input bit align);
    logic [6:0] code;
    code = encode(d);
    if (flip != 0) code[flip-1] = ~code[flip-1];
    if (stop) m = '{dat: d, vld: 1'b1, cor: (flip != 0), fer: 1'b0};
    else begin
      m.vld = 1'b0;
      m.fer = 1'b1;
    end
    sb.push_back(m);
    drive_frame(code, stop, align);
  endtask

  task automatic wait_done(output bit timed_out);
    logic prev;
    prev = io_out[7];
    timed_out = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (prev && !io_out[7]) begin
        timed_out = 1'b0;
        break;
      end
      prev = io_out[7];
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rxd   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (io_out !== 8'h00) begin
      n_err++;
      $display("FAIL reset_hold: io_out=%h required=00", io_out);
    end
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (io_out !== 8'h00) begin
      n_err++;
      $display("FAIL reset_idle: io_out=%h required=00", io_out);
    end
    m = '0;
    sb.delete();
  endtask

  task automatic test_clean();
    exp_t e;
    send(4'hB, 0, 1'b1, 1'b1);
    n_cmp++;
    if (io_out[7] !== 1'b1 || io_out[4] !== 1'b0) begin
      n_err++;
      $display("FAIL clean_in_stop: busy=%b valid=%b required busy=1 valid=0", io_out[7], io_out[4]);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (io_out[7] !== 1'b1) begin
      n_err++;
      $display("FAIL clean_busy_t16: busy=%b required=1", io_out[7]);
    end
    @(posedge clk); #1;
    e = sb.pop_front();
    n_cmp++;
    if (io_out !== {1'b0, exp_vec(e)}) begin
      n_err++;
      $display("FAIL clean_0xB_t17: io_out=%h required=%h", io_out, {1'b0, exp_vec(e)});
    end
  endtask

  task automatic test_single_err();
    exp_t e;
    int   dl[$] = '{11, 11};
    int   fl[$] = '{5, 2};
    for (int d = 0; d < 16; d++)
      for (int f = 0; f < 8; f++) begin
        dl.push_back(d);
        fl.push_back(f);
      end
    foreach (dl[i]) begin
      send(4'(dl[i]), fl[i], 1'b1, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      e = sb.pop_front();
      n_cmp++;
      if (io_out[6:0] !== exp_vec(e) || io_out[7] !== 1'b0) begin
        n_err++;
        $display("FAIL corr d=%h flip=c%0d: io_out=%h required=%h", dl[i], fl[i], io_out, {1'b0, exp_vec(e)});
      end
    end
  endtask

  task automatic test_frame_err();
    exp_t e;
    logic [3:0] dv[3] = '{4'hB, 4'hB, 4'h4};
    logic       sv[3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      send(dv[i], 0, sv[i], 1'b1);
      repeat (2) @(posedge clk);
      #1;
      e = sb.pop_front();
      n_cmp++;
      if (io_out[6:0] !== exp_vec(e)) begin
        n_err++;
        $display("FAIL frame_err step%0d: io_out=%h required=%h", i, io_out, {1'b0, exp_vec(e)});
      end
    end
  endtask

  task automatic test_glitch_b2b();
    exp_t e;
    bit   to;
    int   cnt;
    @(posedge clk); #1;
    rxd = 1'b0;
    @(posedge clk); #1;
    rxd = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (io_out[7] !== 1'b1) begin
      n_err++;
      $display("FAIL glitch_start: busy=%b required=1", io_out[7]);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (io_out !== {1'b0, exp_vec(m)}) begin
      n_err++;
      $display("FAIL glitch_hold: io_out=%h required=%h", io_out, {1'b0, exp_vec(m)});
    end
    fork
      begin
        send(4'h0, 0, 1'b1, 1'b1);
        send(4'hF, 0, 1'b1, 1'b0);
      end
      begin
        wait_done(to);
        e = sb.pop_front();
        n_cmp++;
        if (to || io_out[6:0] !== exp_vec(e)) begin
          n_err++;
          $display("FAIL b2b_first: timeout=%0d io_out=%h required=%h", to, io_out, {1'b0, exp_vec(e)});
        end
        cnt = 0;
        while (io_out[4] && cnt < 10) begin
          @(negedge clk);
          cnt++;
        end
        n_cmp++;
        if (cnt != 2) begin
          n_err++;
          $display("FAIL b2b_valid_drop: cycles=%0d required=2", cnt);
        end
        wait_done(to);
        e = sb.pop_front();
        n_cmp++;
        if (to || io_out[6:0] !== exp_vec(e)) begin
          n_err++;
          $display("FAIL b2b_second: timeout=%0d io_out=%h required=%h", to, io_out, {1'b0, exp_vec(e)});
        end
      end
    join
  endtask

  task automatic test_reset_mid();
    exp_t       e;
    logic [6:0] code;
    code = encode(4'h9);
    @(posedge clk); #1;
    rxd = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      rxd = code[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rxd = code[4];
    @(posedge clk); #1;
    n_cmp++;
    if (io_out[7] !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_busy: busy=%b required=1", io_out[7]);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (io_out !== 8'h00) begin
      n_err++;
      $display("FAIL rst_mid_out: io_out=%h required=00", io_out);
    end
    m = '0;
    sb.delete();
    rxd = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (io_out !== 8'h00) begin
      n_err++;
      $display("FAIL rst_mid_idle: io_out=%h required=00", io_out);
    end
    send(4'h6, 0, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    e = sb.pop_front();
    n_cmp++;
    if (io_out !== {1'b0, exp_vec(e)}) begin
      n_err++;
      $display("FAIL after_rst_0x6: io_out=%h required=%h", io_out, {1'b0, exp_vec(e)});
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single_err();
    test_frame_err();
    test_glitch_b2b();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: sim time %0t reached, required completion earlier", $time);
    $fatal(1, "watchdog");
  end

endmodule
